// File: rtl/vector_data_memory_if.sv
// Memory-stage bus between the filter pipeline and the vector data memory.
// The master issues lane addresses, write data and the request strobe.
// The slave returns the read lanes, a completion pulse and a stall.
`timescale 1ns/1ps
interface vector_data_memory_if #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 10,
  parameter int LANES  = 3
);
  logic                          MemReqM;
  logic                          MemWriteM;
  logic [ADDR_W-1:0]             A1M;
  logic [ADDR_W-1:0]             A2M;
  logic [ADDR_W-1:0]             A3M;
  logic [LANES-1:0][DATA_W-1:0]  writeDataM;
  logic [LANES-1:0][DATA_W-1:0]  RDM;
  logic                          RDValidM;
  logic                          Stall;

  modport master (
    output MemReqM, MemWriteM, A1M, A2M, A3M, writeDataM,
    input  RDM, RDValidM, Stall
  );

  modport slave (
    input  MemReqM, MemWriteM, A1M, A2M, A3M, writeDataM,
    output RDM, RDValidM, Stall
  );
endinterface

// File: rtl/vector_data_memory.sv
// Vector data memory responder for the 3-lane filter datapath.
// A request latches three lane addresses and write words, then the lanes
// are serialized onto one single-port synchronous RAM (lane 0, 1, 2).
// Read data comes back one cycle after each issue, so the capture of lane k
// happens in the state after lane k is issued; LAST only drains lane 2.
`timescale 1ns/1ps
module vector_data_memory #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 10,
  parameter int LANES  = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  vector_data_memory_if.slave  bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LANE0 = 3'd1;
  localparam logic [2:0] LANE1 = 3'd2;
  localparam logic [2:0] LANE2 = 3'd3;
  localparam logic [2:0] LAST  = 3'd4;

  localparam int DEPTH = 1 << ADDR_W;

  logic [2:0]                    state_r;
  logic [2:0]                    state_nxt_s;
  logic                          stall_r;
  logic                          valid_r;
  logic [LANES-1:0][DATA_W-1:0]  rdm_r;

  logic [LANES-1:0][ADDR_W-1:0]  addr_r;
  logic [LANES-1:0][DATA_W-1:0]  wdata_r;
  logic                          write_r;

  logic                          issue_s;
  logic [ADDR_W-1:0]             lane_addr_s;
  logic [DATA_W-1:0]             lane_wdata_s;

  logic [DATA_W-1:0]             mem_r [0:DEPTH-1];
  logic [DATA_W-1:0]             ram_q_r;

  // Next-state sequencing: IDLE waits for a request, then walks the lanes.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.MemReqM) begin
          state_nxt_s = LANE0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LANE0:   state_nxt_s = LANE1;
      LANE1:   state_nxt_s = LANE2;
      LANE2:   state_nxt_s = LAST;
      LAST:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Select which latched lane drives the RAM port in the current state.
  always_comb begin
    issue_s      = 1'b0;
    lane_addr_s  = {ADDR_W{1'b0}};
    lane_wdata_s = {DATA_W{1'b0}};
    case (state_r)
      LANE0: begin
        issue_s      = 1'b1;
        lane_addr_s  = addr_r[0];
        lane_wdata_s = wdata_r[0];
      end
      LANE1: begin
        issue_s      = 1'b1;
        lane_addr_s  = addr_r[1];
        lane_wdata_s = wdata_r[1];
      end
      LANE2: begin
        issue_s      = 1'b1;
        lane_addr_s  = addr_r[2];
        lane_wdata_s = wdata_r[2];
      end
      default: begin
        issue_s      = 1'b0;
        lane_addr_s  = {ADDR_W{1'b0}};
        lane_wdata_s = {DATA_W{1'b0}};
      end
    endcase
  end

  // Control state, registered outputs and operand latch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
      stall_r <= 1'b0;
      valid_r <= 1'b0;
      rdm_r   <= '0;
      addr_r  <= '0;
      wdata_r <= '0;
      write_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      stall_r <= (state_nxt_s != IDLE);
      valid_r <= (state_r == LAST);
      if ((state_r == IDLE) && bus.MemReqM) begin
        addr_r[0] <= bus.A1M;
        addr_r[1] <= bus.A2M;
        addr_r[2] <= bus.A3M;
        wdata_r   <= bus.writeDataM;
        write_r   <= bus.MemWriteM;
      end
      case (state_r)
        LANE1: if (!write_r) rdm_r[0] <= ram_q_r;
        LANE2: if (!write_r) rdm_r[1] <= ram_q_r;
        LAST:  if (!write_r) rdm_r[2] <= ram_q_r;
        default: rdm_r <= rdm_r;
      endcase
    end
  end

  // Single-port RAM; a reset edge suppresses the lane issued in that cycle
  // so an aborted write never commits its unissued lanes.
  always_ff @(posedge CLK) begin
    if (!RST && issue_s) begin
      if (write_r) begin
        mem_r[lane_addr_s] <= lane_wdata_s;
      end else begin
        ram_q_r <= mem_r[lane_addr_s];
      end
    end
  end

  assign bus.RDM      = rdm_r;
  assign bus.RDValidM = valid_r;
  assign bus.Stall    = stall_r;

endmodule

// File: tb/tb_vector_data_memory.sv
// Scoreboard bench for vector_data_memory: the driver pushes the expected
// RDM and acceptance cycle per request, and a monitor pops on RDValidM.
`timescale 1ns/1ps
module tb_vector_data_memory;

  logic CLK = 1'b0;
  logic RST;
  int   cyc = 0;

  vector_data_memory_if bus ();

  vector_data_memory dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc = cyc + 1;

  typedef struct {
    logic [53:0] rdm;
    int          acc;
  } exp_t;

  exp_t        sb_q[$];
  logic [17:0] model_mem [int];
  logic [53:0] exp_rdm = 54'd0;
  int          total_cnt = 0;
  int          pass_cnt  = 0;
  int          stall_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Wait for IDLE at a negedge, with a bounded budget.
  task automatic wait_idle();
    int n = 0;
    while (bus.Stall !== 1'b0 && n < 60) begin
      @(negedge CLK);
      n++;
    end
    if (bus.Stall !== 1'b0) chk("idle_timeout", 64'(bus.Stall), 64'd0);
  endtask

  // Drive one request at the current negedge and push its expectation.
  task automatic issue(input logic wr, input logic [9:0] a1, a2, a3,
                       input logic [17:0] d0, d1, d2);
    exp_t e;
    bus.MemReqM    = 1'b1;
    bus.MemWriteM  = wr;
    bus.A1M        = a1;
    bus.A2M        = a2;
    bus.A3M        = a3;
    bus.writeDataM = {d2, d1, d0};
    if (wr) begin
      model_mem[int'(a1)] = d0;
      model_mem[int'(a2)] = d1;
      model_mem[int'(a3)] = d2;
    end else begin
      exp_rdm = {model_mem[int'(a3)], model_mem[int'(a2)], model_mem[int'(a1)]};
    end
    e.rdm = exp_rdm;
    e.acc = cyc;
    sb_q.push_back(e);
  endtask

  task automatic txn(input logic wr, input logic [9:0] a1, a2, a3,
                     input logic [17:0] d0, d1, d2);
    wait_idle();
    issue(wr, a1, a2, a3, d0, d1, d2);
    @(negedge CLK);
    bus.MemReqM = 1'b0;
    // Scramble the inputs after acceptance; they must have no effect.
    bus.A1M = 10'd777;
    bus.writeDataM = '1;
  endtask

  // Monitor: pop one expectation per completion pulse.
  always @(negedge CLK) begin
    if (RST !== 1'b0) begin
      stall_cnt = 0;
    end else begin
      if (bus.Stall === 1'b1) stall_cnt++;
      if (bus.RDValidM === 1'b1) begin
        if (sb_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_valid: RDValidM=1 with no request pending (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("rdm", 64'(bus.RDM), 64'(e.rdm));
          chk("latency", 64'(cyc - e.acc), 64'd5);
          chk("stall_len", 64'(stall_cnt), 64'd4);
          chk("stall_at_valid", 64'(bus.Stall), 64'd0);
        end
        stall_cnt = 0;
      end
    end
  end

  initial begin
    // Reset with a request present: it must be dropped.
    RST            = 1'b1;
    bus.MemReqM    = 1'b1;
    bus.MemWriteM  = 1'b0;
    bus.A1M        = 10'd0;
    bus.A2M        = 10'd0;
    bus.A3M        = 10'd0;
    bus.writeDataM = '0;
    repeat (3) @(negedge CLK);
    chk("rst_stall", 64'(bus.Stall), 64'd0);
    chk("rst_valid", 64'(bus.RDValidM), 64'd0);
    chk("rst_rdm", 64'(bus.RDM), 64'd0);
    bus.MemReqM = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    chk("no_accept_in_rst", 64'(bus.Stall), 64'd0);

    // Known background contents.
    txn(1'b1, 10'd1022, 10'd1022, 10'd1022, 18'h15555, 18'h15555, 18'h15555);
    txn(1'b1, 10'd200, 10'd201, 10'd199, 18'h0C8C8, 18'h0C9C9, 18'h0C7C7);

    // Write then read.
    txn(1'b1, 10'd5, 10'd6, 10'd4, 18'h3FFFF, 18'h00001, 18'h2AAAA);
    txn(1'b0, 10'd5, 10'd6, 10'd4, 18'h0, 18'h0, 18'h0);

    // Boundary addresses; 1022 must be untouched.
    txn(1'b1, 10'd0, 10'd1, 10'd1023, 18'h11111, 18'h22222, 18'h33333);
    txn(1'b0, 10'd0, 10'd1, 10'd1023, 18'h0, 18'h0, 18'h0);
    txn(1'b0, 10'd1022, 10'd1023, 10'd0, 18'h0, 18'h0, 18'h0);

    // Duplicate write: highest lane wins.
    txn(1'b1, 10'd100, 10'd100, 10'd100, 18'h1, 18'h2, 18'h3);
    txn(1'b0, 10'd100, 10'd100, 10'd100, 18'h0, 18'h0, 18'h0);

    // Held request across three back-to-back reads.
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      wait_idle();
      if (i > 0) chk("valid_at_reaccept", 64'(bus.RDValidM), 64'd1);
      case (i)
        0:       issue(1'b0, 10'd5, 10'd6, 10'd4, 18'h0, 18'h0, 18'h0);
        1:       issue(1'b0, 10'd0, 10'd1, 10'd1023, 18'h0, 18'h0, 18'h0);
        default: issue(1'b0, 10'd100, 10'd100, 10'd100, 18'h0, 18'h0, 18'h0);
      endcase
      @(negedge CLK);
    end
    bus.MemReqM = 1'b0;

    // Reset during LANE1 of a write to {200, 201, 199}.
    wait_idle();
    bus.MemReqM    = 1'b1;
    bus.MemWriteM  = 1'b1;
    bus.A1M        = 10'd200;
    bus.A2M        = 10'd201;
    bus.A3M        = 10'd199;
    bus.writeDataM = {18'h3C7C7, 18'h3C9C9, 18'h3C8C8};
    @(negedge CLK);
    bus.MemReqM = 1'b0;
    @(negedge CLK);
    chk("in_lane1_stall", 64'(bus.Stall), 64'd1);
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_stall", 64'(bus.Stall), 64'd0);
    chk("midrst_valid", 64'(bus.RDValidM), 64'd0);
    chk("midrst_rdm", 64'(bus.RDM), 64'd0);
    RST = 1'b0;
    model_mem[200] = 18'h3C8C8;
    exp_rdm = 54'd0;
    txn(1'b0, 10'd200, 10'd201, 10'd199, 18'h0, 18'h0, 18'h0);

    // A write keeps RDM from the previous read.
    txn(1'b1, 10'd300, 10'd301, 10'd302, 18'hA, 18'hB, 18'hC);
    txn(1'b0, 10'd300, 10'd301, 10'd302, 18'h0, 18'h0, 18'h0);
    txn(1'b1, 10'd400, 10'd401, 10'd402, 18'h1234, 18'h2345, 18'h3456);
    @(negedge CLK);
    chk("rdm_held_in_write", 64'(bus.RDM), 64'({18'hC, 18'hB, 18'hA}));

    // Drain the scoreboard.
    for (int n = 0; n < 40 && sb_q.size() != 0; n++) @(negedge CLK);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    repeat (3) @(negedge CLK);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/vector_data_memory.md
Name: vector_data_memory

Overview:
- Data-memory responder for the 3-lane, 18-bit filter datapath.
- Accepts one vector request per transaction on the memory-stage interface: three 10-bit lane addresses, three 18-bit write lanes and a write flag.
- Serializes the three lane accesses onto a single-port synchronous RAM.
- Holds the pipeline with Stall until the transaction completes, then returns the three read lanes on RDM with a one-cycle valid pulse.

Parameters:
- DATA_W, 18, width of one lane word.
- ADDR_W, 10, address width; RAM depth = 2**ADDR_W words.
- LANES, 3, lanes per request; fixed at 3 in this version.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  synchronous active-high reset.
- MemReqM  input  1  request strobe, sampled only in IDLE.
- MemWriteM  input  1  1 = write request, 0 = read request; sampled with MemReqM.
- A1M  input  10  lane 0 address.
- A2M  input  10  lane 1 address.
- A3M  input  10  lane 2 address.
- writeDataM  input  3x18 packed [2:0][17:0]  write data; lane k goes to address A(k+1)M.
- RDM  output  3x18 packed [2:0][17:0]  read data; lane k comes from address A(k+1)M.
- RDValidM  output  1  one-cycle completion pulse, for both reads and writes.
- Stall  output  1  high while a transaction is in flight.

Behaviour:
- One clock, CLK. Reset is synchronous and active-high on RST.
- Reset values: state IDLE, Stall=0, RDValidM=0, RDM all lanes 18'b0.
- Reset does not clear RAM contents.
- Storage: internal array of 2**ADDR_W x DATA_W.
  - One access per cycle.
  - Synchronous read: the registered output is valid the cycle after the address is issued.
  - Write commits at the clock edge ending the issuing cycle.
- FSM states: IDLE, LANE0, LANE1, LANE2, LAST.
- IDLE:
  - If MemReqM=1 at edge E0, latch A1M..A3M, writeDataM and MemWriteM, then go to LANE0.
  - Otherwise stay in IDLE.
- LANE0: issue lane 0 access (read or write at latched A1); go to LANE1.
- LANE1:
  - Issue lane 1 access.
  - For reads, capture the RAM output into RDM[0] at the end of the cycle.
  - Go to LANE2.
- LANE2:
  - Issue lane 2 access.
  - For reads, capture into RDM[1].
  - Go to LAST.
- LAST:
  - No RAM access.
  - For reads, capture into RDM[2].
  - Set RDValidM for the next cycle; go to IDLE.
- Timing:
  - Stall = 1 exactly in LANE0, LANE1, LANE2 and LAST (registered state decode).
  - RDValidM = 1 exactly in the IDLE cycle following LAST.
  - Latency: request accepted at edge E0 gives RDValidM high in the cycle after edge E4.
- Throughput:
  - A new request may be accepted in the same IDLE cycle where RDValidM=1.
  - Maximum rate is 1 request per 5 cycles.
- MemReqM while Stall=1 is ignored and not queued; the requester must hold or re-issue it.
- Input changes after acceptance have no effect, because all lane operands are latched.
- Write transactions:
  - RDM keeps its previous value.
  - RDValidM still pulses, as a write acknowledge.
- Duplicate addresses within one write: the lanes are written in order 0, 1, 2, so the highest lane wins.
- Duplicate addresses within one read: every duplicated lane returns the same word.
- Addresses are used as given; no arithmetic is done here. 1023 and 0 are ordinary addresses; wrap handling belongs to the requester.
- RST asserted mid-transaction:
  - FSM goes to IDLE; Stall=0, RDValidM=0, RDM=0 after that edge.
  - Lanes already written remain written; unissued lanes are not written.
  - A request present in the same cycle as RST is dropped.

Test Plan:
- Write then read:
  - Stimulus: write A1M=5, A2M=6, A3M=4 with data {0x3FFFF, 0x00001, 0x2AAAA}, then read the same addresses.
  - Required: Stall high 4 cycles for each transaction; RDValidM pulses 5 cycles after each acceptance.
  - Required: the read returns RDM[0]=0x3FFFF, RDM[1]=0x00001, RDM[2]=0x2AAAA.
- Boundary addresses:
  - Stimulus: write A1M=0, A2M=1, A3M=1023 with data {0x11111, 0x22222, 0x33333}, then read.
  - Required: exact readback, and address 1022 remains unchanged.
- Duplicate write:
  - Stimulus: write with A1M=A2M=A3M=100 and data {0x1, 0x2, 0x3}, then read address 100 on all lanes.
  - Required: all lanes return 0x3.
- Ignored request:
  - Stimulus: hold MemReqM=1 continuously across 3 back-to-back reads.
  - Required: exactly one acceptance per 5 cycles; RDValidM high in the same cycle the next request is accepted.
  - Required: no requests are accepted during Stall.
- Reset mid-write:
  - Stimulus: assert RST during LANE1 of a write to {200, 201, 199}.
  - Required: next cycle Stall=0, RDValidM=0, RDM=0; address 200 holds new data; 201 and 199 hold their old data.
- Write keeps RDM:
  - Stimulus: a read returning {0xA, 0xB, 0xC}, then a write to other addresses.
  - Required: RDM stays {0xA, 0xB, 0xC} through the write; RDValidM still pulses.
